bus_arb: RTL

Two-master arbiter for the 16 MB system bus: it shares the single slave-side bus (address decoder plus PROM, RAM, video, I/O) between the CPU (master 0) and a DMA-capable master (master 1, e.g. disk or video DMA). It uses parked round-robin ownership, so a master that keeps its grant pays no arbitration delay. A bus watchdog completes any transfer that gets no acknowledge, so an unmapped or broken slave cannot hang either master. It sits between the masters and the existing address decoder / data and acknowledge multiplexers.

---
 rtl/bus_pkg.sv | 7 +
 rtl/bus_wdog.sv | 19 +
 rtl/bus_arb.sv | 66 ++++++
 3 files changed

// File: rtl/bus_pkg.sv
// bus_pkg: shared encodings and widths for the system bus arbiter.
package bus_pkg;
  typedef enum logic {OWN0 = 1'b0, OWN1 = 1'b1} owner_t;
  localparam int BUS_AW = 22;
  localparam int BUS_DW = 32;
  localparam int DEF_TIMEOUT = 64;
endpackage

// File: rtl/bus_wdog.sv
// bus_wdog: counts unacknowledged strobe cycles and fires on the TIMEOUT-th one.
module bus_wdog
  import bus_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int CW      = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic ack,
  input  logic clr,
  output logic fire
);
  logic [CW-1:0] wcnt;
  always_comb fire = (TIMEOUT != 0) && active && !ack && (wcnt == CW'(TIMEOUT - 1));
  always_ff @(posedge clk)
    wcnt <= (rst || !active || ack || clr || fire || TIMEOUT == 0) ? '0 : wcnt + 1'b1;
endmodule

// File: rtl/bus_arb.sv
// bus_arb: parked round-robin arbiter sharing one slave bus between two masters.
module bus_arb
  import bus_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int CW      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_stb,
  input  logic              m0_we,
  input  logic [BUS_AW-1:0] m0_addr,
  input  logic [BUS_DW-1:0] m0_dout,
  output logic [BUS_DW-1:0] m0_din,
  output logic              m0_ack,
  input  logic              m1_stb,
  input  logic              m1_we,
  input  logic [BUS_AW-1:0] m1_addr,
  input  logic [BUS_DW-1:0] m1_dout,
  output logic [BUS_DW-1:0] m1_din,
  output logic              m1_ack,
  output logic              bus_stb,
  output logic              bus_we,
  output logic [BUS_AW-1:0] bus_addr,
  output logic [BUS_DW-1:0] bus_dout,
  input  logic [BUS_DW-1:0] bus_din,
  input  logic              bus_ack,
  output logic              bus_grant,
  output logic              bus_err
);
  owner_t owner, owner_nxt;
  logic o_stb, other_stb, o_ack, fire, sw;

  always_ff @(posedge clk) owner <= rst ? OWN0 : owner_nxt;

  // A switch only happens between transfers: owner idle or owner being acked.
  always_comb begin
    o_stb     = (owner == OWN1) ? m1_stb : m0_stb;
    other_stb = (owner == OWN1) ? m0_stb : m1_stb;
    o_ack     = bus_ack | fire;
    sw        = other_stb && (!o_stb || o_ack);
    owner_nxt = sw ? ((owner == OWN0) ? OWN1 : OWN0) : owner;
  end

  always_comb begin
    bus_stb   = o_stb && !fire;
    bus_we    = (owner == OWN1) ? m1_we : m0_we;
    bus_addr  = (owner == OWN1) ? m1_addr : m0_addr;
    bus_dout  = (owner == OWN1) ? m1_dout : m0_dout;
    m0_ack    = (owner == OWN0) && o_ack;
    m1_ack    = (owner == OWN1) && o_ack;
    m0_din    = ((owner == OWN0) && fire) ? '0 : bus_din;
    m1_din    = ((owner == OWN1) && fire) ? '0 : bus_din;
    bus_grant = (owner == OWN1);
    bus_err   = fire;
  end

  bus_wdog #(.TIMEOUT(TIMEOUT), .CW(CW)) u_wdog (
    .clk   (clk),
    .rst   (rst),
    .active(o_stb),
    .ack   (bus_ack),
    .clr   (sw),
    .fire  (fire)
  );
endmodule
